// File: rtl/fec_cc_encoder_pkg.sv
// fec_cc_encoder_pkg: block size, generator polynomials, and buffer/encoder state types shared by the encoder
package fec_cc_encoder_pkg;
  localparam int BLOCK_BITS_DEF = 96;
  localparam logic [6:0] G1_DEF = 7'o171;
  localparam logic [6:0] G2_DEF = 7'o133;
  typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL, BUF_ENCODING} buf_state_e;
  typedef enum logic {ENC_IDLE, ENC_ENCODE} enc_state_e;
endpackage

// File: rtl/fec_cc_encoder_if.sv
// fec_cc_encoder_if: serial input and X/Y pair output handshakes; master drives data_in/valid_in/sob_in/out_ready, slave (the encoder) drives ready_in and the pair outputs
interface fec_cc_encoder_if;
  logic data_in;
  logic valid_in;
  logic sob_in;
  logic ready_in;
  logic data_out_x;
  logic data_out_y;
  logic valid_out;
  logic sob_out;
  logic out_ready;
  modport master(
    output data_in, valid_in, sob_in, out_ready,
    input  ready_in, data_out_x, data_out_y, valid_out, sob_out
  );
  modport slave(
    input  data_in, valid_in, sob_in, out_ready,
    output ready_in, data_out_x, data_out_y, valid_out, sob_out
  );
endinterface

// File: rtl/fec_cc_encoder_cc_core.sv
// fec_cc_encoder_cc_core: K=7 shift state with tail-biting load and registered X/Y; ports clk, reset (sync, active-low), en/load/last/init/u in, x/y out
module fec_cc_encoder_cc_core
  import fec_cc_encoder_pkg::*;
#(
  parameter logic [6:0] G1 = G1_DEF,
  parameter logic [6:0] G2 = G2_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic       last,
  input  logic [5:0] init,
  input  logic       u,
  output logic       x,
  output logic       y
);
  logic [5:0] s_q, s_d, s_cur, init_q, init_d;
  logic       x_q, x_d, y_q, y_d;
  always_comb begin
    s_cur = load ? init : s_q;
    s_d = en ? {u, s_cur[5:1]} : s_q;
    x_d = en ? ^({u, s_cur} & G1) : x_q;
    y_d = en ? ^({u, s_cur} & G2) : y_q;
    init_d = load ? init : init_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_q <= '0;
      init_q <= '0;
      x_q <= 1'b0;
      y_q <= 1'b0;
    end else begin
      s_q <= s_d;
      init_q <= init_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assert property (@(posedge clk) disable iff (!reset) (en && last) |-> (s_d == init_q));
  assign x = x_q;
  assign y = y_q;
endmodule

// File: rtl/fec_cc_encoder.sv
// fec_cc_encoder: rate-1/2 K=7 tail-biting encoder with ping-pong block buffers; ports clk, reset (sync, active-low), bus (slave: serial bit in, X/Y pair out)
module fec_cc_encoder
  import fec_cc_encoder_pkg::*;
#(
  parameter int         BLOCK_BITS = BLOCK_BITS_DEF,
  parameter logic [6:0] G1         = G1_DEF,
  parameter logic [6:0] G2         = G2_DEF
) (
  input logic             clk,
  input logic             reset,
  fec_cc_encoder_if.slave bus
);
  localparam int CW = $clog2(BLOCK_BITS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BITS - 1);
  logic [BLOCK_BITS-1:0] mem_q [2];
  logic [BLOCK_BITS-1:0] mem_d [2];
  buf_state_e            bst_q [2];
  buf_state_e            bst_d [2];
  enc_state_e            state_q, state_d;
  logic                  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_idx, rd_idx;
  logic                  valid_q, valid_d, sob_q, sob_d;
  logic                  ready, acc, take, start, step, last, u;
  logic [5:0]            init;
  // the output register is free when empty or being drained this cycle
  always_comb begin
    ready = bst_q[wr_sel_q] != BUF_FULL && bst_q[wr_sel_q] != BUF_ENCODING;
    acc = bus.valid_in && ready;
    wr_idx = bus.sob_in ? '0 : wr_cnt_q;
    take = bus.out_ready || !valid_q;
    start = state_q == ENC_IDLE && bst_q[rd_sel_q] == BUF_FULL && take;
    step = state_q == ENC_ENCODE && take;
    last = step && rd_cnt_q == LAST;
    rd_idx = start ? '0 : rd_cnt_q;
    u = mem_q[rd_sel_q][rd_idx];
    init = mem_q[rd_sel_q][BLOCK_BITS-1 -: 6];
    mem_d = mem_q;
    bst_d = bst_q;
    wr_cnt_d = wr_cnt_q;
    wr_sel_d = wr_sel_q;
    if (acc) begin
      mem_d[wr_sel_q][wr_idx] = bus.data_in;
      bst_d[wr_sel_q] = wr_idx == LAST ? BUF_FULL : BUF_FILLING;
      wr_cnt_d = wr_idx == LAST ? '0 : wr_idx + 1'b1;
      wr_sel_d = wr_sel_q ^ (wr_idx == LAST);
    end
    // the buffer is released once its last bit sits in the output register, so the writer can reuse it without a stall
    if (start) bst_d[rd_sel_q] = BUF_ENCODING;
    if (last) bst_d[rd_sel_q] = BUF_EMPTY;
    state_d = start ? ENC_ENCODE : last ? ENC_IDLE : state_q;
    rd_cnt_d = start ? CW'(1) : last ? '0 : step ? rd_cnt_q + 1'b1 : rd_cnt_q;
    rd_sel_d = rd_sel_q ^ last;
    valid_d = start || step || (valid_q && !take);
    sob_d = start || (sob_q && !take);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) begin
      bst_q <= '{BUF_EMPTY, BUF_EMPTY};
      state_q <= ENC_IDLE;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      valid_q <= 1'b0;
      sob_q <= 1'b0;
    end else begin
      bst_q <= bst_d;
      state_q <= state_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      valid_q <= valid_d;
      sob_q <= sob_d;
    end
  end
  fec_cc_encoder_cc_core #(.G1(G1), .G2(G2)) u_core (
    .clk  (clk),
    .reset(reset),
    .en   (start || step),
    .load (start),
    .last (last),
    .init (init),
    .u    (u),
    .x    (bus.data_out_x),
    .y    (bus.data_out_y)
  );
  assign bus.ready_in = ready;
  assign bus.valid_out = valid_q;
  assign bus.sob_out = sob_q;
endmodule

// File: tb/tb_fec_cc_encoder.sv
// tb_fec_cc_encoder: directed-vector bench for the tail-biting convolutional encoder
module tb_fec_cc_encoder;
  localparam logic [95:0]  STD       = 96'h558AC4A53A1724E163AC2BF9;
  localparam logic [191:0] STD_OUT   = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
  localparam logic [95:0]  IMP1      = {1'b1, 95'b0};
  localparam logic [191:0] IMP1_OUT  = {16'hEF1C, 176'h0};
  localparam logic [95:0]  IMP96     = 96'h1;
  localparam logic [191:0] IMP96_OUT = {12'hBC7, 178'b0, 2'b11};
  localparam logic [95:0]  BLK_A     = 96'hF0E1D2C3B4A5968778695A4B;
  localparam logic [95:0]  BLK_B     = 96'h0123456789ABCDEF13579BDF;
  localparam logic [95:0]  BLK_C     = 96'h3C96E10F7B24D85A0C6F91E3;
  localparam logic [95:0]  SOB1      = {1'b1, 95'b0};
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int acc_cnt = 0;
  logic [2:0] pq[$];
  int tq[$];
  fec_cc_encoder_if bus();
  fec_cc_encoder dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.valid_out && bus.out_ready) begin
      pq.push_back({bus.sob_out, bus.data_out_x, bus.data_out_y});
      tq.push_back(cyc);
    end
    if (bus.valid_in && bus.ready_in) acc_cnt++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end
  function automatic logic [191:0] cc_ref(input logic [95:0] blk);
    logic [6:1] s;
    logic u;
    logic [191:0] r;
    for (int k = 1; k <= 6; k++) s[k] = blk[k-1];
    for (int i = 1; i <= 96; i++) begin
      u = blk[96-i];
      r[193-2*i] = u ^ s[1] ^ s[2] ^ s[3] ^ s[6];
      r[192-2*i] = u ^ s[2] ^ s[3] ^ s[5] ^ s[6];
      s = {s[5:1], u};
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put_bit(input logic d, input logic s);
    int n;
    n = 0;
    bus.data_in = d;
    bus.valid_in = 1'b1;
    bus.sob_in = s;
    @(negedge clk);
    while (!bus.ready_in && n < 1000) begin
      stall_cnt++;
      @(negedge clk);
      n++;
    end
    if (!bus.ready_in) chk("ready_timeout", bus.ready_in, 1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.sob_in = 1'b0;
  endtask
  task automatic send_block(input logic [95:0] blk, input logic sob);
    for (int i = 0; i < 96; i++) put_bit(blk[95-i], sob && i == 0);
  endtask
  task automatic wait_pairs(input int n);
    int t;
    t = 0;
    while (pq.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (pq.size() < n) chk("pairs_timeout", pq.size(), n);
  endtask
  task automatic expect_block(input string tag, input logic [191:0] exp);
    logic [191:0] s;
    logic [95:0] f;
    logic [2:0] e;
    for (int i = 0; i < 96; i++) begin
      e = 3'b0;
      if (pq.size() != 0) e = pq.pop_front();
      f[95-i] = e[2];
      s[191-2*i] = e[1];
      s[190-2*i] = e[0];
    end
    chk(tag, s, exp);
    chk({tag, "_sob"}, f, SOB1);
  endtask
  task automatic run_block(input string tag, input logic [95:0] blk, input logic [191:0] exp);
    pq.delete();
    @(posedge clk);
    #1;
    send_block(blk, 1'b1);
    wait_pairs(96);
    expect_block(tag, exp);
  endtask
  initial begin
    logic [191:0] e;
    bus.data_in = 1'b0;
    bus.valid_in = 1'b0;
    bus.sob_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.ready_in, 1);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_x", bus.data_out_x, 0);
    chk("rst_y", bus.data_out_y, 0);
    chk("rst_sob", bus.sob_out, 0);
    run_block("std", STD, STD_OUT);
    run_block("imp1", IMP1, IMP1_OUT);
    run_block("imp96", IMP96, IMP96_OUT);
    pq.delete();
    tq.delete();
    stall_cnt = 0;
    @(posedge clk);
    #1;
    send_block(BLK_A, 1'b1);
    send_block(BLK_B, 1'b1);
    send_block(BLK_C, 1'b1);
    wait_pairs(288);
    chk("b2b_stall", stall_cnt, 0);
    chk("b2b_contig", tq.size() >= 288 ? tq[287] - tq[0] : -1, 287);
    expect_block("b2b_0", cc_ref(BLK_A));
    expect_block("b2b_1", cc_ref(BLK_B));
    expect_block("b2b_2", cc_ref(BLK_C));
    pq.delete();
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    acc_cnt = 0;
    fork
      begin
        send_block(BLK_B, 1'b1);
        send_block(STD, 1'b1);
        send_block(BLK_A, 1'b1);
      end
    join_none
    repeat (250) @(negedge clk);
    e = cc_ref(BLK_B);
    chk("bp_accepted", acc_cnt, 192);
    chk("bp_ready", bus.ready_in, 0);
    chk("bp_valid", bus.valid_out, 1);
    chk("bp_sob", bus.sob_out, 1);
    chk("bp_pair1", {bus.data_out_x, bus.data_out_y}, e[191:190]);
    chk("bp_no_transfer", pq.size(), 0);
    bus.out_ready = 1'b1;
    wait_pairs(288);
    expect_block("bp_0", cc_ref(BLK_B));
    expect_block("bp_1", STD_OUT);
    expect_block("bp_2", cc_ref(BLK_A));
    pq.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) put_bit(i[0], i == 0);
    send_block(BLK_C, 1'b1);
    wait_pairs(96);
    expect_block("realign", cc_ref(BLK_C));
    repeat (150) @(negedge clk);
    chk("realign_extra", pq.size(), 0);
    pq.delete();
    @(posedge clk);
    #1;
    send_block(STD, 1'b1);
    wait_pairs(50);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.valid_out, 0);
    chk("mid_rst_x", bus.data_out_x, 0);
    chk("mid_rst_y", bus.data_out_y, 0);
    chk("mid_rst_sob", bus.sob_out, 0);
    chk("mid_rst_ready", bus.ready_in, 1);
    pq.delete();
    repeat (150) @(negedge clk);
    chk("mid_rst_quiet", pq.size(), 0);
    run_block("post_rst", BLK_A, cc_ref(BLK_A));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
